mio_arb: RTL and testbench

MIO_ARB -- requirements
Module: mio_arb

---
 rtl/mio_arb.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mio_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_arb.sv
`default_nettype none
// ============================================================================
// Module   : mio_arb
// Purpose  : Two-requester memory/IO arbiter. Grants one requester at a time,
//            checks the request for legality, forwards legal requests to the
//            downstream L1D/IO port and returns the completion (ack, load data,
//            error) to the granted requester only.
// Ports    : clk_in, reset_n_in            clock, async active-low reset
//            r0_*/r1_* inputs              request, rd/wr, addr, wdata, size,
//                                          zero_ext per requester
//            r0_*/r1_* outputs             ack pulse, rd_data, err
//            m_req, m_rd, m_wr, m_rw_addr,
//            m_wr_data, m_size, m_zero_ext downstream request (registered)
//            m_ack, m_rd_data              downstream completion
//            busy, grant_id                status
// Config   : `define MIO_ARB_TIMEOUT_EN to abort an ISSUE that receives no
//            m_ack within TIMEOUT_CYC cycles (completes with err=1).
// Revision : 1.0 - initial release
// ============================================================================
module mio_arb #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    // requester 0
    input  logic        r0_req,
    input  logic        r0_rd,
    input  logic        r0_wr,
    input  logic [31:0] r0_rw_addr,
    input  logic [31:0] r0_wr_data,
    input  logic [2:0]  r0_size,
    input  logic        r0_zero_ext,
    output logic        r0_ack,
    output logic [31:0] r0_rd_data,
    output logic        r0_err,
    // requester 1
    input  logic        r1_req,
    input  logic        r1_rd,
    input  logic        r1_wr,
    input  logic [31:0] r1_rw_addr,
    input  logic [31:0] r1_wr_data,
    input  logic [2:0]  r1_size,
    input  logic        r1_zero_ext,
    output logic        r1_ack,
    output logic [31:0] r1_rd_data,
    output logic        r1_err,
    // downstream
    output logic        m_req,
    output logic        m_rd,
    output logic        m_wr,
    output logic [31:0] m_rw_addr,
    output logic [31:0] m_wr_data,
    output logic [2:0]  m_size,
    output logic        m_zero_ext,
    input  logic        m_ack,
    input  logic [31:0] m_rd_data,
    // status
    output logic        busy,
    output logic        grant_id
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    // Catch an out-of-range timeout at elaboration rather than silently
    // truncating it into the 10-bit counter compare.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
        $error("mio_arb: TIMEOUT_CYC must be in 1..1023");
    end

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_last;      // requester granted most recently
    logic        r_grant;
    logic        r_m_rd;
    logic        r_m_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_size;
    logic        r_zext;
    logic [31:0] r_rdata;
    logic        r_err;

`ifdef MIO_ARB_TIMEOUT_EN
    localparam logic [9:0] c_TIMEOUT_LAST = 10'(TIMEOUT_CYC - 1);
    logic [9:0]  r_cnt;
    logic        w_timeout;
    assign w_timeout = (r_cnt == c_TIMEOUT_LAST);
`endif

    // ------------------------------------------------------------------
    // Arbitration and request selection
    // ------------------------------------------------------------------
    logic        w_any;
    logic        w_winner;
    logic        w_sel_rd;
    logic        w_sel_wr;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [2:0]  w_sel_size;
    logic        w_sel_zext;
    logic        w_aligned;
    logic        w_valid;

    assign w_any = r0_req | r1_req;
    // On a tie the requester that did not win last time gets the bus.
    assign w_winner = (r0_req & r1_req) ? ~r_last : r1_req;

    always_comb begin
        w_sel_rd    = r0_rd;
        w_sel_wr    = r0_wr;
        w_sel_addr  = r0_rw_addr;
        w_sel_wdata = r0_wr_data;
        w_sel_size  = r0_size;
        w_sel_zext  = r0_zero_ext;
        if (w_winner) begin
            w_sel_rd    = r1_rd;
            w_sel_wr    = r1_wr;
            w_sel_addr  = r1_rw_addr;
            w_sel_wdata = r1_wr_data;
            w_sel_size  = r1_size;
            w_sel_zext  = r1_zero_ext;
        end
    end

    // Sizes other than 1/2/4 bytes are illegal and reported as misaligned.
    always_comb begin
        w_aligned = 1'b0;
        case (w_sel_size)
            3'd1:    w_aligned = 1'b1;
            3'd2:    w_aligned = ~w_sel_addr[0];
            3'd4:    w_aligned = (w_sel_addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_valid = (w_sel_rd != w_sel_wr) & w_aligned;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_state_nxt = w_valid ? c_ISSUE : c_RESP;
                end
            end
            c_ISSUE: begin
                if (m_ack) begin
                    w_state_nxt = c_RESP;
                end
`ifdef MIO_ARB_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = c_RESP;
                end
`endif
            end
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request / response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_last  <= 1'b1;   // r0 wins the first tie
            r_grant <= 1'b0;
            r_m_rd  <= 1'b0;
            r_m_wr  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_zext  <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                        r_m_rd  <= w_sel_rd;
                        r_m_wr  <= w_sel_wr;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_size  <= w_sel_size;
                        r_zext  <= w_sel_zext;
                        r_rdata <= '0;
                        r_err   <= ~w_valid;
                    end
                end
                c_ISSUE: begin
                    if (m_ack) begin
                        r_rdata <= r_m_wr ? 32'd0 : m_rd_data;
                        r_err   <= 1'b0;
                    end
`ifdef MIO_ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef MIO_ARB_TIMEOUT_EN
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_cnt <= '0;
        end else if (r_state == c_ISSUE) begin
            r_cnt <= r_cnt + 10'd1;
        end else begin
            r_cnt <= '0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_resp;
    assign w_resp = (r_state == c_RESP);

    assign m_req      = (r_state == c_ISSUE);
    assign m_rd       = r_m_rd;
    assign m_wr       = r_m_wr;
    assign m_rw_addr  = r_addr;
    assign m_wr_data  = r_wdata;
    assign m_size     = r_size;
    assign m_zero_ext = r_zext;

    assign busy     = (r_state != c_IDLE);
    assign grant_id = r_grant;

    // Only the granted requester ever sees non-zero response outputs.
    assign r0_ack     = w_resp & ~r_grant;
    assign r0_rd_data = r0_ack ? r_rdata : 32'd0;
    assign r0_err     = r0_ack & r_err;
    assign r1_ack     = w_resp & r_grant;
    assign r1_rd_data = r1_ack ? r_rdata : 32'd0;
    assign r1_err     = r1_ack & r_err;

endmodule
`default_nettype wire

// File: tb/tb_mio_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mio_arb
// Purpose  : Self-checking bench for mio_arb. Stimulus pushes the expected
//            requester response into a queue; a monitor pops and compares on
//            every rN_ack. Timeout expectations follow MIO_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mio_arb;

    localparam int c_TO = 8;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        r0_req, r0_rd, r0_wr, r0_zero_ext;
    logic [31:0] r0_rw_addr, r0_wr_data;
    logic [2:0]  r0_size;
    logic        r0_ack, r0_err;
    logic [31:0] r0_rd_data;
    logic        r1_req, r1_rd, r1_wr, r1_zero_ext;
    logic [31:0] r1_rw_addr, r1_wr_data;
    logic [2:0]  r1_size;
    logic        r1_ack, r1_err;
    logic [31:0] r1_rd_data;
    logic        m_req, m_rd, m_wr, m_zero_ext, m_ack;
    logic [31:0] m_rw_addr, m_wr_data, m_rd_data;
    logic [2:0]  m_size;
    logic        busy, grant_id;

    always #5 clk_in = ~clk_in;

    mio_arb #(.TIMEOUT_CYC(c_TO)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .r0_req(r0_req), .r0_rd(r0_rd), .r0_wr(r0_wr), .r0_rw_addr(r0_rw_addr),
        .r0_wr_data(r0_wr_data), .r0_size(r0_size), .r0_zero_ext(r0_zero_ext),
        .r0_ack(r0_ack), .r0_rd_data(r0_rd_data), .r0_err(r0_err),
        .r1_req(r1_req), .r1_rd(r1_rd), .r1_wr(r1_wr), .r1_rw_addr(r1_rw_addr),
        .r1_wr_data(r1_wr_data), .r1_size(r1_size), .r1_zero_ext(r1_zero_ext),
        .r1_ack(r1_ack), .r1_rd_data(r1_rd_data), .r1_err(r1_err),
        .m_req(m_req), .m_rd(m_rd), .m_wr(m_wr), .m_rw_addr(m_rw_addr),
        .m_wr_data(m_wr_data), .m_size(m_size), .m_zero_ext(m_zero_ext),
        .m_ack(m_ack), .m_rd_data(m_rd_data),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Monitor: response scoreboard plus quiet-output check for the other port.
    always @(negedge clk_in) begin
        exp_t e;
        if (reset_n_in === 1'b1) begin
            if (!r0_ack) check("r0_quiet", {r0_err, r0_rd_data}, 0);
            if (!r1_ack) check("r1_quiet", {r1_err, r1_rd_data}, 0);
            if (r0_ack || r1_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {r1_ack, r0_ack}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_id", {r1_ack, r0_ack}, e.id ? 2'b10 : 2'b01);
                    check("rd_data", e.id ? r1_rd_data : r0_rd_data, e.data);
                    check("err", e.id ? r1_err : r0_err, e.err);
                end
            end
        end
    end

    task automatic drive(input int id, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] sz, input logic zx);
        if (id == 0) begin
            r0_rd = rd; r0_wr = wr; r0_rw_addr = addr; r0_wr_data = wd;
            r0_size = sz; r0_zero_ext = zx; r0_req = 1'b1;
        end else begin
            r1_rd = rd; r1_wr = wr; r1_rw_addr = addr; r1_wr_data = wd;
            r1_size = sz; r1_zero_ext = zx; r1_req = 1'b1;
        end
    endtask

    task automatic drop(input int id);
        if (id == 0) r0_req = 1'b0;
        else         r1_req = 1'b0;
    endtask

    task automatic push(input logic id, input logic [31:0] d, input logic err);
        exp_t e;
        e.id = id; e.data = d; e.err = err;
        exp_q.push_back(e);
    endtask

    // Returns at a negedge with m_req high, or flags a failed bound.
    task automatic wait_mreq(input string name);
        int n = 0;
        @(negedge clk_in);
        while (m_req !== 1'b1 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check(name, m_req, 1);
    endtask

    task automatic pulse_ack(input logic [31:0] d);
        @(posedge clk_in); #1;
        m_ack = 1'b1; m_rd_data = d;
        @(posedge clk_in); #1;
        m_ack = 1'b0; m_rd_data = 32'd0;
    endtask

    // Returns at the negedge where the requester's ack is high.
    task automatic wait_ack(input int id, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (((id == 0) ? r0_ack : r1_ack) !== 1'b1 && cyc < 40);
        if (cyc >= 40) check("ack_wait_bound", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        logic        iv_rd[4];
        logic        iv_wr[4];
        logic [31:0] iv_addr[4];
        logic [2:0]  iv_sz[4];
        logic        saw;

        reset_n_in = 1'b0;
        r0_req = 0; r0_rd = 0; r0_wr = 0; r0_rw_addr = 0; r0_wr_data = 0; r0_size = 0; r0_zero_ext = 0;
        r1_req = 0; r1_rd = 0; r1_wr = 0; r1_rw_addr = 0; r1_wr_data = 0; r1_size = 0; r1_zero_ext = 0;
        m_ack = 0; m_rd_data = 0;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_m_req", m_req, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_acks", {r1_ack, r0_ack, r1_err, r0_err}, 0);
        check("rst_rdata", {r1_rd_data, r0_rd_data}, 0);
        reset_n_in = 1'b1;

        // r0 load; requester drops req mid-transaction but still gets ack
        @(posedge clk_in); #1;
        drive(0, 1, 0, 32'h100, 32'h0, 3'd4, 0);
        wait_mreq("load_mreq");
        check("load_fields", {m_rd, m_wr, m_size, m_rw_addr}, {1'b1, 1'b0, 3'd4, 32'h100});
        check("load_busy_grant", {busy, grant_id}, 2'b10);
        drop(0);
        push(0, 32'hDEADBEEF, 0);
        @(posedge clk_in);
        pulse_ack(32'hDEADBEEF);
        wait_ack(0, cyc);
        check("load_ack_latency", cyc, 1);
        check("load_mreq_dropped", m_req, 0);

        // Tie from reset: grant order r0, r1, r0
        @(posedge clk_in); #1;
        reset_n_in = 1'b0;
        @(posedge clk_in); #1;
        reset_n_in = 1'b1;
        drive(0, 1, 0, 32'h200, 32'h0, 3'd4, 0);
        drive(1, 0, 1, 32'h300, 32'h12345678, 3'd2, 0);
        for (int k = 0; k < 3; k++) begin
            logic exp_id;
            exp_id = (k == 1);
            wait_mreq("tie_mreq");
            check("tie_grant", grant_id, exp_id);
            if (exp_id) check("tie_wr_fields", {m_wr, m_wr_data}, {1'b1, 32'h12345678});
            push(exp_id, exp_id ? 32'h0 : 32'hA0 + k, 0);
            pulse_ack(exp_id ? 32'hFFFF0000 : 32'hA0 + k);
            wait_ack(exp_id, cyc);
            if (k == 2) begin
                drop(0);
                drop(1);
            end
        end

        // Illegal r1 requests: rd==wr, bad size, misaligned, neither rd nor wr
        iv_rd[0] = 1; iv_wr[0] = 1; iv_addr[0] = 32'h100; iv_sz[0] = 3'd4;
        iv_rd[1] = 1; iv_wr[1] = 0; iv_addr[1] = 32'h100; iv_sz[1] = 3'd3;
        iv_rd[2] = 1; iv_wr[2] = 0; iv_addr[2] = 32'h102; iv_sz[2] = 3'd4;
        iv_rd[3] = 0; iv_wr[3] = 0; iv_addr[3] = 32'h100; iv_sz[3] = 3'd2;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #1;
            drive(1, iv_rd[k], iv_wr[k], iv_addr[k], 32'h0, iv_sz[k], 0);
            push(1, 32'h0, 1);
            cyc = 0;
            saw = 1'b0;
            do begin
                @(negedge clk_in);
                cyc++;
                saw |= m_req;
            end while (r1_ack !== 1'b1 && cyc < 20);
            drop(1);
            check("invalid_latency", cyc, 2);
            check("invalid_no_mreq", saw, 0);
        end

        // Boundary-legal byte access at odd address with zero-extend
        @(posedge clk_in); #1;
        drive(1, 1, 0, 32'h103, 32'h0, 3'd1, 1);
        wait_mreq("byte_mreq");
        check("byte_fields", {m_size, m_zero_ext, m_rw_addr}, {3'd1, 1'b1, 32'h103});
        push(1, 32'h000000AB, 0);
        pulse_ack(32'h000000AB);
        wait_ack(1, cyc);
        drop(1);

        // m_ack while idle is ignored
        pulse_ack(32'h5555AAAA);
        repeat (3) @(negedge clk_in);
        check("idle_ack_ignored", {busy, m_req}, 0);

        // No downstream response
        @(posedge clk_in); #1;
        drive(0, 1, 0, 32'h400, 32'h0, 3'd4, 0);
        wait_mreq("to_mreq");
        n = 0;
`ifdef MIO_ARB_TIMEOUT_EN
        push(0, 32'h0, 1);
        while (m_req === 1'b1 && n < 50) begin
            n++;
            @(negedge clk_in);
        end
        check("to_mreq_cycles", n, c_TO);
        check("to_ack", r0_ack, 1);
        drop(0);
`else
        while (m_req === 1'b1 && n < 20) begin
            n++;
            @(negedge clk_in);
        end
        check("noto_mreq_held", n, 20);
        push(0, 32'h77, 0);
        pulse_ack(32'h77);
        wait_ack(0, cyc);
        drop(0);
`endif

        // Reset mid-ISSUE aborts; late m_ack ignored
        @(posedge clk_in); #1;
        drive(1, 1, 0, 32'h500, 32'h0, 3'd4, 0);
        wait_mreq("abort_mreq");
        #1;
        reset_n_in = 1'b0;
        #1;
        check("abort_outputs", {m_req, busy, grant_id, r0_ack, r1_ack}, 0);
        drop(1);
        @(posedge clk_in); #1;
        reset_n_in = 1'b1;
        pulse_ack(32'h99);
        repeat (4) @(negedge clk_in);
        check("abort_after", {m_req, busy}, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
